// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scan_pkg
//  Purpose  : Shared constants and state encoding for the channel scanner.
//  Revision : 1.0  initial release
// ============================================================================
package scan_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/channel_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : channel_scanner_if
//  Purpose  : Control, multiplexer and frame handshake signals of the scanner.
//  Revision : 1.0  initial release
// ============================================================================
interface channel_scanner_if
  import scan_pkg::*;
#(
  parameter int DWELL_W = 4
);

  logic               start;
  logic               cont;
  logic [N_CH-1:0]    ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]   sel;
  logic               mux_out;
  logic [N_CH-1:0]    frame;
  logic               frame_valid;
  logic               frame_ready;
  logic               busy;

  // Scanner side
  modport master (
    input  start, cont, ch_mask, dwell, mux_out, frame_ready,
    output sel, frame, frame_valid, busy
  );

  // Environment side (controller, multiplexer and frame consumer)
  modport slave (
    output start, cont, ch_mask, dwell, mux_out, frame_ready,
    input  sel, frame, frame_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/scan_next_ch.sv
`default_nettype none
// ============================================================================
//  Module   : scan_next_ch
//  Purpose  : Finds the next enabled channel strictly above an index, or the
//             lowest enabled channel when i_first is set.
//  Revision : 1.0  initial release
// ============================================================================
module scan_next_ch
  import scan_pkg::*;
(
  input  wire logic [N_CH-1:0]  i_mask,
  input  wire logic [SEL_W-1:0] i_idx,
  input  wire logic             i_first,
  output logic      [SEL_W-1:0] o_next,
  output logic                  o_last
);

  // Descending scan so the lowest qualifying channel is the one that sticks
  always_comb begin
    o_next = '0;
    o_last = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i > int'(i_idx)))) begin
        o_next = SEL_W'(i);
        o_last = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/channel_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : channel_scanner
//  Purpose  : Steps an 8:1 mux select through the enabled channels, settles
//             each for dwell+1 cycles, samples and delivers an 8-bit frame on
//             a valid/ready handshake (single-shot or continuous).
//  Revision : 1.0  initial release
// ============================================================================
module channel_scanner
  import scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  channel_scanner_if.master bus
);

  scan_state_t        r_state,  w_state_nxt;
  logic [DWELL_W-1:0] r_cnt,    w_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell,  w_dwell_nxt;
  logic [N_CH-1:0]    r_mask,   w_mask_nxt;
  logic [N_CH-1:0]    r_shadow, w_shadow_nxt;
  logic [N_CH-1:0]    r_frame,  w_frame_nxt;
  logic [SEL_W-1:0]   r_sel,    w_sel_nxt;
  logic               r_valid,  w_valid_nxt;

  logic [SEL_W-1:0]   w_first_ch;
  logic               w_first_none;
  logic [SEL_W-1:0]   w_next_ch;
  logic               w_next_last;
  logic [N_CH-1:0]    w_shadow_smp;
  logic               w_mask_nz;

  // First enabled channel of the live mask, used when a scan (re)starts
  scan_next_ch u_first (
    .i_mask  (bus.ch_mask),
    .i_idx   ('0),
    .i_first (1'b1),
    .o_next  (w_first_ch),
    .o_last  (w_first_none)
  );

  // Next enabled channel above the current select within the latched mask
  scan_next_ch u_next (
    .i_mask  (r_mask),
    .i_idx   (r_sel),
    .i_first (1'b0),
    .o_next  (w_next_ch),
    .o_last  (w_next_last)
  );

  assign w_mask_nz = ~w_first_none;

  // Shadow frame with the current mux sample merged in at the select position
  always_comb begin
    w_shadow_smp        = r_shadow;
    w_shadow_smp[r_sel] = bus.mux_out;
  end

  // Next-state and datapath: defaults hold everything, states override
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dwell_nxt  = r_dwell;
    w_mask_nxt   = r_mask;
    w_shadow_nxt = r_shadow;
    w_frame_nxt  = r_frame;
    w_sel_nxt    = r_sel;
    w_valid_nxt  = r_valid;

    unique case (r_state)
      IDLE: begin
        if (bus.start && w_mask_nz) begin
          w_mask_nxt   = bus.ch_mask;
          w_dwell_nxt  = bus.dwell;
          w_shadow_nxt = '0;
          w_sel_nxt    = w_first_ch;
          w_cnt_nxt    = bus.dwell;
          w_state_nxt  = SETTLE;
        end
      end

      SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end else begin
          w_shadow_nxt = w_shadow_smp;
          if (!w_next_last) begin
            w_sel_nxt = w_next_ch;
            w_cnt_nxt = r_dwell;
          end else begin
            w_frame_nxt = w_shadow_smp;
            w_valid_nxt = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end

      HOLD: begin
        if (r_valid && bus.frame_ready) begin
          w_valid_nxt = 1'b0;
          if (bus.cont && w_mask_nz) begin
            // Back-to-back restart behaves exactly like an accepted start
            w_mask_nxt   = bus.ch_mask;
            w_dwell_nxt  = bus.dwell;
            w_shadow_nxt = '0;
            w_sel_nxt    = w_first_ch;
            w_cnt_nxt    = bus.dwell;
            w_state_nxt  = SETTLE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dwell  <= '0;
      r_mask   <= '0;
      r_shadow <= '0;
      r_frame  <= '0;
      r_sel    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dwell  <= w_dwell_nxt;
      r_mask   <= w_mask_nxt;
      r_shadow <= w_shadow_nxt;
      r_frame  <= w_frame_nxt;
      r_sel    <= w_sel_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign bus.sel         = r_sel;
  assign bus.frame       = r_frame;
  assign bus.frame_valid = r_valid;
  assign bus.busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_channel_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_channel_scanner
//  Purpose  : Self-checking bench for channel_scanner with randomized scans
//             compared against a channel-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_channel_scanner;

  logic       clk;
  logic       rst;
  logic [7:0] vec;          // the eight multiplexer inputs
  int         total;
  int         bad;
  int         last_sel;     // model: select left behind by the last frame
  logic [7:0] cur_frame;    // model: frame currently presented

  channel_scanner_if #(.DWELL_W(4)) bus_if ();

  channel_scanner #(.DWELL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // 8:1 multiplexer model driven by the scanner select
  assign bus_if.mux_out = vec[bus_if.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: run did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Request a scan; returns at the falling edge after the start edge
  task automatic kick(input logic [7:0] mask, input int dw);
    bus_if.start       = 1'b1;
    bus_if.ch_mask     = mask;
    bus_if.dwell       = 4'(dw);
    bus_if.cont        = 1'b0;
    bus_if.frame_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  // Walk one frame: each enabled channel, in ascending order, owns the select
  // for dw+1 cycles and is sampled with the inputs present at its last edge.
  task automatic scan_frame(input logic [7:0] mask, input int dw,
                            input bit fixed, input logic [7:0] fvec);
    int         chans[$];
    logic [7:0] exp_f;
    exp_f = 8'h00;
    for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
    foreach (chans[k]) begin
      for (int j = 0; j <= dw; j++) begin
        chk_eq("sel_scan",   32'(bus_if.sel), 32'(chans[k]));
        chk_eq("busy_scan",  32'(bus_if.busy), 32'd1);
        chk_eq("valid_scan", 32'(bus_if.frame_valid), 32'd0);
        vec = fixed ? fvec : 8'($urandom);
        if (j == dw) exp_f[chans[k]] = vec[chans[k]];
        // Noise on controls that must not disturb a running scan
        bus_if.start   = 1'($urandom);
        bus_if.ch_mask = 8'($urandom);
        bus_if.dwell   = 4'($urandom);
        bus_if.cont    = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
      end
    end
    bus_if.start = 1'b0;
    chk_eq("valid_up",  32'(bus_if.frame_valid), 32'd1);
    chk_eq("frame",     32'(bus_if.frame), 32'(exp_f));
    chk_eq("busy_hold", 32'(bus_if.busy), 32'd1);
    last_sel  = chans[chans.size() - 1];
    cur_frame = exp_f;
  endtask

  // Stall for some cycles, then handshake; reports whether it restarted
  task automatic deliver(input int stall, input bit cv, input logic [7:0] nm,
                         input int nd, output bit restarted);
    for (int s = 0; s < stall; s++) begin
      bus_if.frame_ready = 1'b0;
      bus_if.start       = 1'($urandom);
      bus_if.ch_mask     = 8'($urandom);
      bus_if.cont        = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk_eq("frame_stall", 32'(bus_if.frame), 32'(cur_frame));
      chk_eq("valid_stall", 32'(bus_if.frame_valid), 32'd1);
      chk_eq("busy_stall",  32'(bus_if.busy), 32'd1);
      chk_eq("sel_stall",   32'(bus_if.sel), 32'(last_sel));
    end
    bus_if.frame_ready = 1'b1;
    bus_if.cont        = cv;
    bus_if.ch_mask     = nm;
    bus_if.dwell       = 4'(nd);
    bus_if.start       = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    bus_if.frame_ready = 1'b0;
    bus_if.start       = 1'b0;
    bus_if.cont        = 1'b0;
    chk_eq("valid_drop", 32'(bus_if.frame_valid), 32'd0);
    restarted = cv && (nm != 8'h00);
    if (!restarted) begin
      chk_eq("busy_idle",  32'(bus_if.busy), 32'd0);
      chk_eq("sel_idle",   32'(bus_if.sel), 32'(last_sel));
      chk_eq("frame_keep", 32'(bus_if.frame), 32'(cur_frame));
    end
  endtask

  initial begin
    bit         rs;
    logic [7:0] m;
    int         d;
    total = 0;
    bad   = 0;
    last_sel  = 0;
    cur_frame = 8'h00;
    vec = 8'h00;
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.cont = 1'b0; bus_if.ch_mask = 8'h00;
    bus_if.dwell = 4'd0; bus_if.frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("rst_sel",   32'(bus_if.sel), 32'd0);
    chk_eq("rst_frame", 32'(bus_if.frame), 32'd0);
    chk_eq("rst_valid", 32'(bus_if.frame_valid), 32'd0);
    chk_eq("rst_busy",  32'(bus_if.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Empty mask: start ignored
    kick(8'h00, 2);
    for (int c = 0; c < 3; c++) begin
      chk_eq("zm_busy",  32'(bus_if.busy), 32'd0);
      chk_eq("zm_sel",   32'(bus_if.sel), 32'd0);
      chk_eq("zm_valid", 32'(bus_if.frame_valid), 32'd0);
      @(negedge clk);
    end

    // All channels, no dwell, fixed inputs
    kick(8'hFF, 0);
    scan_frame(8'hFF, 0, 1'b1, 8'hA5);
    chk_eq("frame_a5", 32'(bus_if.frame), 32'hA5);
    deliver(0, 1'b0, 8'hFF, 0, rs);

    // Channels 0 and 7 with dwell 3, then a long stall with noise
    kick(8'h81, 3);
    scan_frame(8'h81, 3, 1'b1, 8'hFF);
    chk_eq("frame_81", 32'(bus_if.frame), 32'h81);
    deliver(5, 1'b0, 8'h3C, 2, rs);

    // Asynchronous reset in the middle of a scan
    kick(8'hFF, 0);
    repeat (3) begin
      vec = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_sel",   32'(bus_if.sel), 32'd0);
    chk_eq("arst_frame", 32'(bus_if.frame), 32'd0);
    chk_eq("arst_valid", 32'(bus_if.frame_valid), 32'd0);
    chk_eq("arst_busy",  32'(bus_if.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_sel  = 0;
    cur_frame = 8'h00;
    @(negedge clk);
    kick(8'hC3, 2);
    scan_frame(8'hC3, 2, 1'b0, 8'h00);
    deliver(1, 1'b0, 8'h00, 0, rs);

    // Continuous mode with toggling inputs
    kick(8'h0F, 1);
    scan_frame(8'h0F, 1, 1'b0, 8'h00);
    for (int f = 0; f < 3; f++) begin
      deliver(0, 1'b1, 8'h0F, 1, rs);
      scan_frame(8'h0F, 1, 1'b0, 8'h00);
    end
    deliver(0, 1'b0, 8'h0F, 1, rs);

    // Randomized scans, stalls and restart chains
    for (int n = 0; n < 30; n++) begin
      m = 8'($urandom_range(1, 255));
      d = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      kick(m, d);
      scan_frame(m, d, 1'b0, 8'h00);
      rs = 1'b1;
      for (int c = 0; c < 4 && rs; c++) begin
        m = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        d = int'($urandom_range(0, 3));
        deliver(int'($urandom_range(0, 3)), (c < 3) ? 1'($urandom) : 1'b0, m, d, rs);
        if (rs) scan_frame(m, d, 1'b0, 8'h00);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/channel_scanner.md
# channel_scanner

Sequencer that sits in front of the 8:1 single-bit multiplexer and drives its 3-bit select. It steps the select through a programmable set of enabled channels, holding each for a programmable settle time. It samples the multiplexer output once per channel and assembles the samples into an 8-bit frame. The frame is delivered downstream on a valid/ready handshake, either once per start pulse or continuously.

## Interface

Clock is `clk`. Reset is `rst`: one clock; reset is asynchronous and active-high.

Parameters:
- `DWELL_W`, default 4: width of the per-channel dwell setting.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous active-high reset.
- `start` input 1: scan request; sampled only in IDLE.
- `cont` input 1: continuous mode; sampled at each frame handshake.
- `ch_mask` input 8: enabled channels; bit i enables mux input i.
- `dwell` input DWELL_W: extra settle cycles per channel.
- `sel` output 3: select to the multiplexer.
- `mux_out` input 1: multiplexer output.
- `frame` output 8: assembled samples; bit i is the channel i sample.
- `frame_valid` output 1: frame available.
- `frame_ready` input 1: downstream accepts the frame.
- `busy` output 1: high whenever state is not IDLE.

## Operation

States: IDLE, SETTLE, HOLD.

IDLE:
- `start`=1 with `ch_mask`≠0 is accepted at the clock edge. At that edge the block:
  - latches `ch_mask` and `dwell` into internal registers;
  - clears the shadow frame;
  - sets `sel` to the lowest enabled index;
  - loads `cnt` with `dwell`;
  - moves to SETTLE.
- `start` with `ch_mask`=0 is ignored.

SETTLE, on each edge:
- If `cnt`≠0: decrement `cnt`.
- If `cnt`=0: write `mux_out` into shadow bit `sel`. Then:
  - if a higher enabled channel exists, set `sel` to it, reload `cnt` with the latched dwell, and stay in SETTLE;
  - otherwise, load `frame` with the shadow value including the bit just sampled, set `frame_valid`=1, and go to HOLD.

HOLD:
- `frame` and `frame_valid` are held stable until an edge where `frame_valid`&&`frame_ready`. At that edge `frame_valid` goes to 0.
- If `cont`=1 and the current `ch_mask`≠0 at that edge, the block restarts exactly as an accepted start, re-latching `ch_mask` and `dwell`.
- Otherwise it goes to IDLE.

General rules:
- Disabled channels always read 0 in `frame`.
- `start` is ignored outside IDLE.
- Changes to `ch_mask` or `dwell` during a scan have no effect until the next latch.
- `sel` keeps its last value in IDLE and HOLD. `frame` keeps its value until the next frame load.

Reset values (asynchronous, immediate, from any state including mid-scan):
- `sel`=0, `frame`=0, `frame_valid`=0, `busy`=0.
- State IDLE; `cnt`, shadow frame and latched mask/dwell all 0.

## Timing

- Every enabled channel keeps `sel` stable for exactly dwell+1 cycles. `mux_out` is sampled at the last edge of that window.
- With K enabled channels and start accepted at edge E0:
  - samples are taken at edges E0+k·(dwell+1), for k=1..K;
  - `frame_valid` rises immediately after edge E0+K·(dwell+1).
- `busy` rises after E0. It falls after the handshake edge unless the block restarts.
- Continuous mode: `sel` moves to the first channel at the handshake edge, with no idle cycle. Frame period is K·(dwell+1) cycles plus any `frame_ready` stall.
- `dwell` is unsigned. Maximum hold per channel is 2^DWELL_W cycles. `cnt` never wraps: reload always happens at 0.
- Single-channel mask: one window, then straight to HOLD.
- Mask bit 7 as the last channel: no wrap to channel 0 within a frame.

## Structure

Package `scan_pkg`:
- `N_CH`=8 and `SEL_W`=3.
- `typedef enum logic [1:0] {IDLE, SETTLE, HOLD} scan_state_t`.

Sub-module `scan_next_ch`, combinational:
- Inputs: mask and current index.
- Outputs: the next enabled index strictly above the current one, plus a `last` flag.
- The first-channel search reuses it with a "below 0" query: a `first` input selects search-from-bottom.

## Test plan

1. `ch_mask`=FF, `dwell`=0, bench mux inputs=8'hA5, start pulse -> `sel` steps 0..7 one per cycle; `frame_valid` 8 cycles after the start edge; `frame`=A5.
2. `ch_mask`=81, `dwell`=3, inputs=FF -> `sel`=0 for 4 cycles, then 7 for 4 cycles; `frame_valid` at cycle 8; `frame`=81.
3. In HOLD, `frame_ready` low for 5 cycles with extra `start` pulses and `ch_mask` changes -> `frame`, `frame_valid`=1 and `busy`=1 stable; handshake then drops `frame_valid`; back in IDLE.
4. `cont`=1, `ch_mask`=0F, `dwell`=1, `frame_ready`=1, inputs toggling -> `sel`=0 in the cycle after each handshake; new frame every 8 cycles; each frame matches the inputs at its sample edges.
5. `ch_mask`=00, start pulse -> `busy` stays 0, `sel` stays 0, no `frame_valid`.
6. Assert `rst` mid-SETTLE, asynchronously between edges -> `sel`, `frame`, `frame_valid` and `busy` go to 0 before the next edge; a subsequent start produces a correct frame.
